pcie_tx_arb_merge: RTL
======================

# pcie_tx_arb_merge

Merges two independent PCIe TX AXI-S streams into one, arbitrating only at TLP boundaries. The block sits directly upstream of the ch0 TX aligner and feeds it. Typical sources are host-channel DMA TX and MMIO completion TX. Grants alternate round-robin, and a grant is held until the granted source closes its open TLP. The merged stream leaves through an optional 2-entry registered skid buffer.

## Interface
Parameters:
- REG_OUT, default 1 — 1: output goes through a 2-entry skid buffer; 0: combinational passthrough of the granted beat.

Ports:
- clk  in  1  — single clock for all logic.
- rst_n  in  1  — asynchronous, active-low reset.
- axis_tx_st_in0  ofs_fim_pcie_txs_axis_if.slave  t_axis_pcie_txs — source 0.
- axis_tx_st_in1  ofs_fim_pcie_txs_axis_if.slave  t_axis_pcie_txs — source 1.
- axis_tx_st_out  ofs_fim_pcie_txs_axis_if.master  t_axis_pcie_txs — merged stream. Its clk and rst_n are driven from clk and rst_n.
- arb_locked  out  2  — one-hot: source currently holding an open-TLP lock.

## Operation
- Open beat: the highest-index slot with valid=1 has eop=0. Closed beat: that slot has eop=1. Empty beat: tvalid=1 with no slot valid.
- States:
  - IDLE: no lock.
  - LOCK0 / LOCK1: source 0 or 1 owns the output.
- IDLE grant rules:
  - Only one source has tvalid: that source is granted.
  - Both have tvalid: grant the source that is not last_grant.
  - The grant is combinational, so the beat is accepted in the same cycle the grant is made.
- State transitions on an accepted beat from source x:
  - Open beat: go to LOCKx.
  - Closed beat: stay in or return to IDLE.
  - In both cases set last_grant=x.
- In LOCKx:
  - Only source x gets tready. The other source's tready=0.
  - The state leaves LOCKx only on an accepted closed beat from x.
- A beat with eop in ch0 and a new sop-without-eop in ch1 is open, so the lock is retained.
- Empty beats are consumed (tready follows the grant rules) and dropped. They change neither state nor last_grant.
- Beats are forwarded unmodified: tdata, tuser and tlast are copied verbatim.
- No FIM_PCIE_TLP_CH restriction applies. Open/closed is evaluated over all channels.

## Timing
- Reset values:
  - State: IDLE.
  - last_grant: 1, so source 0 wins the first tie.
  - Skid buffer: empty; axis_tx_st_out.tx.tvalid=0.
  - axis_tx_st_in*.tready: 0.
  - arb_locked: 2'b00.
- REG_OUT=1:
  - Latency from input accept to out tvalid is 1 cycle.
  - Input tready depends only on registered skid occupancy: granted tready=1 iff the skid buffer is not full.
  - Full throughput of 1 beat/clk while out tready=1.
  - out tready deasserted: at most 2 beats are absorbed, then input tready drops the next cycle.
- REG_OUT=0: latency 0; granted tready = out tready.
- Output holds tdata/tuser/tlast stable while tvalid=1 and tready=0 (AXI-S rule).
- Simultaneous accept and drain of the full skid buffer (REG_OUT=1): tready uses the registered full flag, so the beat is not accepted that cycle. There is no combinational path out.tready→in.tready.
- Reset asserted mid-TLP: state returns to IDLE immediately and the skid buffer is flushed. A partial TLP may be lost. Upstream is reset by the same rst_n.
- Arbitration is work-conserving: no idle cycles between TLPs from alternating sources.

## Structure
- Add to ofs_fim_pcie_pkg:
  - Function pcie_txs_beat_is_open(t_axis_pcie_txs) returning the open flag.
  - Function pcie_txs_beat_is_empty(t_axis_pcie_txs).
  - Enum t_tx_arb_state {ARB_IDLE, ARB_LOCK0, ARB_LOCK1}.
- Sub-module pcie_txs_skid_buf: 2-entry AXI-S skid buffer on t_axis_pcie_txs with async active-low reset. It is instantiated when REG_OUT=1 and is reusable elsewhere.

## Test plan
- Both sources present single-beat closed TLPs every cycle, out tready=1 -> output alternates in0,in1,in0,... with in0 first after reset and 1 beat/clk.
- in0 sends a 3-beat TLP (sop ch0 / mid / eop ch1) while in1 holds tvalid -> in1 tready=0 for all 3 beats, arb_locked=2'b01, and the in1 beat appears on cycle 4.
- in0 beat with eop in ch0 plus sop-open in ch1, then a closed beat -> lock held across both beats, then IDLE.
- out tready held 0 for 5 cycles during continuous in0 traffic -> exactly 2 beats buffered, in0 tready=0 by the cycle after full, and no beat lost or duplicated on release.
- Empty beat (tvalid=1, all slot valid=0) on in1 in IDLE -> consumed, nothing output, last_grant unchanged.
- rst_n pulsed low mid-LOCK1 -> out tvalid=0 and arb_locked=0 asynchronously; after release, in0 wins the first tie.

Source files
------------

// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe TX AXI-S beat format, arbiter state encoding and beat classification helpers.
package ofs_fim_pcie_pkg;

    localparam int FIM_PCIE_TLP_CH = 2;
    localparam int FIM_PCIE_SEG_W  = 32;
    localparam int FIM_PCIE_DATA_W = FIM_PCIE_TLP_CH * FIM_PCIE_SEG_W;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } t_pcie_txs_slot_user;

    typedef struct packed {
        logic                                       tvalid;
        logic                                       tlast;
        t_pcie_txs_slot_user [FIM_PCIE_TLP_CH-1:0]  tuser;
        logic [FIM_PCIE_DATA_W-1:0]                 tdata;
    } t_axis_pcie_txs;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOCK0,
        ARB_LOCK1
    } t_tx_arb_state;

    // The last valid slot decides: a TLP left without eop keeps the beat open.
    function automatic logic pcie_txs_beat_is_open(input t_axis_pcie_txs b);
        logic open;
        open = 1'b0;
        for (int i = 0; i < FIM_PCIE_TLP_CH; i++) begin
            if (b.tuser[i].valid) open = !b.tuser[i].eop;
        end
        return open;
    endfunction

    function automatic logic pcie_txs_beat_is_empty(input t_axis_pcie_txs b);
        logic any_valid;
        any_valid = 1'b0;
        for (int i = 0; i < FIM_PCIE_TLP_CH; i++) begin
            any_valid = any_valid | b.tuser[i].valid;
        end
        return b.tvalid && !any_valid;
    endfunction

endpackage

// File: rtl/ofs_fim_pcie_txs_axis_if.sv
// PCIe TX AXI-S stream bundle: one beat struct plus tready, with its clock and reset.
interface ofs_fim_pcie_txs_axis_if;
    import ofs_fim_pcie_pkg::*;

    logic           clk;
    logic           rst_n;
    t_axis_pcie_txs tx;
    logic           tready;

    modport master (output clk, output rst_n, output tx, input tready);
    modport slave  (input tx, output tready);

endinterface

// File: rtl/pcie_txs_skid_buf.sv
// Two-entry registered AXI-S buffer; in_ready comes only from registered occupancy.
module pcie_txs_skid_buf
    import ofs_fim_pcie_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  t_axis_pcie_txs in_beat,
    output logic           in_ready,
    output t_axis_pcie_txs out_beat,
    input  logic           out_ready
);

    t_axis_pcie_txs mem_q [2];
    t_axis_pcie_txs mem_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     count_q, count_d;
    logic           push, pop;

    always_comb begin
        in_ready        = (count_q != 2'd2);
        out_beat        = mem_q[rd_ptr_q];
        out_beat.tvalid = (count_q != 2'd0);
        push            = in_beat.tvalid && in_ready;
        pop             = out_beat.tvalid && out_ready;
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_beat;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) rd_ptr_d = !rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pcie_tx_arb_merge.sv
// Round-robin merge of two PCIe TX streams; grants switch only at TLP boundaries.
module pcie_tx_arb_merge
    import ofs_fim_pcie_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    ofs_fim_pcie_txs_axis_if.slave          axis_tx_st_in0,
    ofs_fim_pcie_txs_axis_if.slave          axis_tx_st_in1,
    ofs_fim_pcie_txs_axis_if.master         axis_tx_st_out,
    output logic [1:0]                      arb_locked
);

    t_tx_arb_state  state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [1:0]     arb_locked_q, arb_locked_d;
    logic           run_q;

    t_axis_pcie_txs beat0, beat1, sel_beat, fwd_beat, out_beat;
    logic           v0, v1, sel_src, sel_vld, sel_empty, accepted;
    logic [1:0]     grant;
    logic           can_accept, skid_in_ready, tready0, tready1;

    assign beat0 = axis_tx_st_in0.tx;
    assign beat1 = axis_tx_st_in1.tx;

    always_comb begin
        v0    = beat0.tvalid;
        v1    = beat1.tvalid;
        grant = 2'b00;
        case (state_q)
            ARB_LOCK0: grant = 2'b01;
            ARB_LOCK1: grant = 2'b10;
            default: begin
                if (v0 && v1)  grant = last_grant_q ? 2'b01 : 2'b10;
                else if (v0)   grant = 2'b01;
                else if (v1)   grant = 2'b10;
            end
        endcase

        // run_q keeps tready low through reset without a comb path from out.tready.
        can_accept = run_q && (REG_OUT ? skid_in_ready : axis_tx_st_out.tready);
        tready0    = grant[0] && can_accept;
        tready1    = grant[1] && can_accept;

        sel_src         = grant[1];
        sel_beat        = sel_src ? beat1 : beat0;
        sel_vld         = |(grant & {v1, v0});
        sel_empty       = pcie_txs_beat_is_empty(sel_beat);
        fwd_beat        = sel_beat;
        fwd_beat.tvalid = sel_vld && !sel_empty;
        accepted        = sel_vld && (sel_src ? tready1 : tready0);

        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (accepted && !sel_empty) begin
            last_grant_d = sel_src;
            if (pcie_txs_beat_is_open(sel_beat)) state_d = sel_src ? ARB_LOCK1 : ARB_LOCK0;
            else                                 state_d = ARB_IDLE;
        end
        arb_locked_d = {state_d == ARB_LOCK1, state_d == ARB_LOCK0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            arb_locked_q <= 2'b00;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            arb_locked_q <= arb_locked_d;
            run_q        <= 1'b1;
        end
    end

    generate
        if (REG_OUT) begin : g_skid
            pcie_txs_skid_buf u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_beat   (fwd_beat),
                .in_ready  (skid_in_ready),
                .out_beat  (out_beat),
                .out_ready (axis_tx_st_out.tready)
            );
        end else begin : g_pass
            assign skid_in_ready = 1'b1;
            assign out_beat      = fwd_beat;
        end
    endgenerate

    assign axis_tx_st_in0.tready = tready0;
    assign axis_tx_st_in1.tready = tready1;
    assign axis_tx_st_out.tx     = out_beat;
    assign axis_tx_st_out.clk    = clk;
    assign axis_tx_st_out.rst_n  = rst_n;
    assign arb_locked            = arb_locked_q;

endmodule
